mux_scan_serializer: RTL and testbench
======================================

Name: mux_scan_serializer

Overview:
- Scan controller that sits directly upstream of the 32-to-1 mux stage.
- Accepts a 32-bit word over a valid/ready handshake and steps the 5-bit select through all 32 positions, asserting the enable while it scans.
- Emits the selected bit as a serial stream with valid/ready backpressure, and pulses done once the last bit is taken.
- Contains its own registered copy of the word and its own 32:1 bit-select, so the stream is self-contained. The s/en outputs can also drive an external mux bank directly.

Parameters:
- WIDTH, 32: word width and number of scan positions. Must equal 2**SEL_W.
- SEL_W, 5: select width.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- load_valid, input, 1: upstream offers a word.
- load_ready, output, 1: block can accept a word; high only in IDLE.
- load_data, input, WIDTH: word to serialize.
- msb_first, input, 1: scan order, sampled on load. 0 = positions 0..31, 1 = positions 31..0.
- abort, input, 1: synchronous cancel of the scan in progress.
- s, output, SEL_W: current select position.
- en, output, 1: select enable; high only in SHIFT.
- ser_out, output, 1: equals en AND data_q[s].
- ser_valid, output, 1: serial bit valid; equals en.
- ser_ready, input, 1: downstream accepts the current bit.
- busy, output, 1: high in SHIFT and DONE.
- done, output, 1: one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, data_q=0, s=0, en=0, ser_out=0, ser_valid=0, done=0, busy=0. load_ready=1 as soon as reset is released. Reset asserted mid-scan drops all outputs immediately and discards the word; no done pulse.
- States: IDLE, SHIFT, DONE. State is registered; load_ready, en, ser_valid, busy and done decode directly from state.
- IDLE:
  - load_ready=1.
  - On load_valid=1, capture data_q<=load_data and dir_q<=msb_first, set s<=(msb_first ? WIDTH-1 : 0), go to SHIFT.
  - load_valid=0 keeps IDLE; s holds its last value and en=0.
- SHIFT:
  - en=1, ser_valid=1, ser_out=data_q[s] (combinational from registers, no extra latency).
  - Handshake is ser_valid AND ser_ready in the same cycle. On handshake at a non-final position, s steps by +1 (LSB-first) or -1 (MSB-first).
  - Final position is 31 for LSB-first and 0 for MSB-first. Handshake there goes to DONE; s holds.
  - ser_ready=0: s, ser_out and ser_valid hold stable for any number of cycles.
  - load_valid is ignored (load_ready=0); data_q never changes mid-scan.
  - abort=1: go to IDLE next cycle, no done pulse. Abort in the same cycle as the final handshake also wins: IDLE, no done.
- DONE:
  - done=1, busy=1, en=0, load_ready=0 for exactly one cycle, then IDLE.
  - abort is ignored in DONE.
- Timing:
  - Word accepted at edge N; first bit valid in cycle N+1.
  - With ser_ready held high, the last bit is taken in cycle N+32, done is high in cycle N+33, and the earliest next load is cycle N+34.
- Select arithmetic: s never wraps. Stepping stops at the final position, and the FSM guarantees no step beyond it.

Test Plan:
- Load 0x77777777, msb_first=0, ser_ready=1:
  - s runs 0..31 on consecutive cycles.
  - ser_out repeats 1,1,1,0 eight times.
  - done is a single pulse 33 cycles after load; load_ready returns one cycle later.
- Load 0x80000001, msb_first=1:
  - s runs 31..0.
  - ser_out is 1, then 30 zeros, then 1.
  - Exactly 32 handshakes occur before done.
- Backpressure: during the 0x77777777 scan, drop ser_ready for 3 cycles at s=5:
  - s stays 5, ser_out stays 1, ser_valid stays 1.
  - Scan resumes at 6; total scan length is 35 cycles.
- Busy loads: pulse load_valid with 0xFFFFFFFF at s=12 and again in the DONE cycle:
  - Both are ignored; stream and done are unaffected.
  - A load in the following IDLE cycle is accepted.
- Abort:
  - abort=1 at s=20 → IDLE next cycle, en=0, no done, load_ready=1.
  - abort coincident with the final handshake → no done.
- Async reset: drive rst_n low mid-cycle at s=10:
  - s=0, en=0, ser_valid=0, busy=0 immediately, with no clock edge.
  - After release, load_ready=1 and a fresh 0x77777777 load scans from 0.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// Scan controller for a 32:1 mux stage: captures a word, walks the select through every
// position and streams the selected bit out under valid/ready backpressure.
module mux_scan_serializer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  input  logic             abort,
  output logic [SEL_W-1:0] s,
  output logic             en,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [SEL_W-1:0] SelLast = SEL_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [SEL_W-1:0] s_q;
  logic             at_final;
  logic             handshake;

  // Final position depends on scan direction; stepping never passes it.
  assign at_final  = dir_q ? (s_q == '0) : (s_q == SelLast);
  assign handshake = ser_valid & ser_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      dir_q   <= 1'b0;
      s_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_valid) begin
            data_q  <= load_data;
            dir_q   <= msb_first;
            s_q     <= msb_first ? SelLast : '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          // Abort takes priority, even over the final handshake.
          if (abort) begin
            state_q <= StIdle;
          end else if (handshake) begin
            if (at_final) begin
              state_q <= StDone;
            end else begin
              s_q <= dir_q ? (s_q - 1'b1) : (s_q + 1'b1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign load_ready = (state_q == StIdle);
  assign en         = (state_q == StShift);
  assign ser_valid  = en;
  assign busy       = (state_q == StShift) || (state_q == StDone);
  assign done       = (state_q == StDone);
  assign s          = s_q;
  assign ser_out    = en & data_q[s_q];

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Self-checking bench for mux_scan_serializer: expected stream derived from the word and
// scan order by plain arithmetic, with randomized words and backpressure.
module tb_mux_scan_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        msb_first;
  logic        abort;
  logic [4:0]  s;
  logic        en;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  mux_scan_serializer #(.WIDTH(32), .SEL_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .msb_first  (msb_first),
    .abort      (abort),
    .s          (s),
    .en         (en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference model: the idx-th bit sent is at position idx (LSB-first) or 31-idx (MSB-first).
  function automatic int exp_pos(input logic m, input int idx);
    return m ? (31 - idx) : idx;
  endfunction

  function automatic logic exp_bit(input logic [31:0] w, input logic m, input int idx);
    int p;
    p = exp_pos(m, idx);
    if (p < 0 || p > 31) return 1'bx;
    return w[p];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for load_ready, then offers the word for exactly one edge.
  task automatic load_word(input logic [31:0] w, input logic m);
    int waitc;
    waitc = 0;
    while (load_ready !== 1'b1 && waitc < 100) begin
      tick();
      waitc++;
    end
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_wait: load_ready=%b required 1", load_ready);
    end
    load_valid = 1'b1;
    load_data  = w;
    msb_first  = m;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({s, en, ser_valid, busy, done, ser_out} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: s=%0d en=%b valid=%b busy=%b done=%b ser_out=%b required all 0",
               s, en, ser_valid, busy, done, ser_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (load_ready !== 1'b1 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: load_ready=%b en=%b required 1 0", load_ready, en);
    end
  endtask

  task automatic test_lsb_scan();
    logic [31:0] w;
    w = 32'h7777_7777;
    ser_ready = 1'b1;
    load_word(w, 1'b0);
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (s !== 5'(k) || ser_out !== ((k % 4) != 3) || ser_valid !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL lsb_scan k=%0d: s=%0d ser_out=%b valid=%b done=%b required s=%0d ser_out=%b valid=1 done=0",
                 k, s, ser_out, ser_valid, done, k, ((k % 4) != 3));
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_done: done=%b busy=%b load_ready=%b en=%b required 1 1 0 0",
               done, busy, load_ready, en);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_after_done: done=%b busy=%b load_ready=%b required 0 0 1",
               done, busy, load_ready);
    end
  endtask

  task automatic test_msb_scan();
    logic [31:0] w;
    int idx, cyc;
    logic hs;
    w = 32'h8000_0001;
    idx = 0;
    cyc = 0;
    load_word(w, 1'b1);
    while (done !== 1'b1 && cyc < 200) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      if (en === 1'b1) begin
        n_checks++;
        if (s !== 5'(exp_pos(1'b1, idx)) || ser_out !== ((idx == 0) || (idx == 31))) begin
          n_fail++;
          $display("FAIL msb_scan idx=%0d: s=%0d ser_out=%b required s=%0d ser_out=%b",
                   idx, s, ser_out, exp_pos(1'b1, idx), ((idx == 0) || (idx == 31)));
        end
      end
      hs = en & ser_ready;
      tick();
      cyc++;
      if (hs) idx++;
    end
    ser_ready = 1'b1;
    n_checks++;
    if (done !== 1'b1 || idx != 32) begin
      n_fail++;
      $display("FAIL msb_handshakes: done=%b handshakes=%0d required done=1 handshakes=32", done, idx);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic m, hs;
    int idx, cyc;
    for (int t = 0; t < 6; t++) begin
      w = $urandom;
      m = 1'($urandom_range(0, 1));
      idx = 0;
      cyc = 0;
      load_word(w, m);
      while (idx < 32 && cyc < 400) begin
        ser_ready = 1'($urandom_range(0, 1));
        n_checks++;
        if (s !== 5'(exp_pos(m, idx)) || ser_out !== exp_bit(w, m, idx) ||
            ser_valid !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL random w=%h m=%b idx=%0d: s=%0d ser_out=%b valid=%b done=%b required s=%0d ser_out=%b valid=1 done=0",
                   w, m, idx, s, ser_out, ser_valid, done, exp_pos(m, idx), exp_bit(w, m, idx));
        end
        hs = en & ser_ready;
        tick();
        cyc++;
        if (hs) idx++;
      end
      ser_ready = 1'b1;
      n_checks++;
      if (done !== 1'b1 || en !== 1'b0 || load_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL random_done w=%h: done=%b en=%b load_ready=%b required 1 0 0",
                 w, done, en, load_ready);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    int idx, cyc, stall;
    logic hs;
    w = 32'h7777_7777;
    idx = 0;
    cyc = 0;
    stall = 0;
    load_word(w, 1'b0);
    while (en === 1'b1 && cyc < 100) begin
      ser_ready = !(idx == 5 && stall < 3);
      if (!ser_ready) stall++;
      n_checks++;
      if (s !== 5'(idx) || ser_out !== exp_bit(w, 1'b0, idx) || ser_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure cyc=%0d: s=%0d ser_out=%b valid=%b required s=%0d ser_out=%b valid=1",
                 cyc, s, ser_out, ser_valid, idx, exp_bit(w, 1'b0, idx));
      end
      hs = en & ser_ready;
      tick();
      cyc++;
      if (hs) idx++;
    end
    ser_ready = 1'b1;
    n_checks++;
    if (cyc != 35 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_len: scan cycles=%0d done=%b required 35 1", cyc, done);
    end
    tick();
  endtask

  task automatic test_busy_loads();
    logic [31:0] w, w2;
    int cyc;
    w = 32'h7777_7777;
    ser_ready = 1'b1;
    load_word(w, 1'b0);
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (s !== 5'(k) || ser_out !== exp_bit(w, 1'b0, k) || en !== 1'b1 || load_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_stream k=%0d: s=%0d ser_out=%b en=%b load_ready=%b required s=%0d ser_out=%b en=1 load_ready=0",
                 k, s, ser_out, en, load_ready, k, exp_bit(w, 1'b0, k));
      end
      load_valid = (k == 12);
      load_data  = 32'hFFFF_FFFF;
      msb_first  = 1'b1;
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_done: done=%b load_ready=%b required 1 0", done, load_ready);
    end
    load_valid = 1'b1;
    load_data  = 32'hFFFF_FFFF;
    msb_first  = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || load_ready !== 1'b1 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_done_load: done=%b load_ready=%b en=%b required 0 1 0", done, load_ready, en);
    end
    w2 = $urandom;
    load_data = w2;
    tick();
    load_valid = 1'b0;
    n_checks++;
    if (en !== 1'b1 || s !== 5'd0 || ser_out !== w2[0]) begin
      n_fail++;
      $display("FAIL idle_load: en=%b s=%0d ser_out=%b required en=1 s=0 ser_out=%b",
               en, s, ser_out, w2[0]);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] w;
    logic m;
    w = $urandom;
    ser_ready = 1'b1;
    load_word(w, 1'b0);
    repeat (20) tick();
    n_checks++;
    if (s !== 5'd20 || en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: s=%0d en=%b required 20 1", s, en);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (en !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_mid: en=%b done=%b load_ready=%b busy=%b required 0 0 1 0",
               en, done, load_ready, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_mid_nodone: done=%b required 0", done);
    end
    // Abort coincident with the final handshake.
    w = $urandom;
    m = 1'($urandom_range(0, 1));
    load_word(w, m);
    repeat (31) tick();
    n_checks++;
    if (s !== 5'(exp_pos(m, 31)) || en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_final_pre: s=%0d en=%b required s=%0d en=1", s, en, exp_pos(m, 31));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b0 || load_ready !== 1'b1 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_final: done=%b load_ready=%b en=%b required 0 1 0", done, load_ready, en);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_final_nodone: done=%b required 0", done);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    w = 32'h7777_7777;
    ser_ready = 1'b1;
    load_word(w, 1'b0);
    repeat (10) tick();
    n_checks++;
    if (s !== 5'd10) begin
      n_fail++;
      $display("FAIL areset_pre: s=%0d required 10", s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (s !== 5'd0 || en !== 1'b0 || ser_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: s=%0d en=%b valid=%b busy=%b done=%b required all 0",
               s, en, ser_valid, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (load_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release: load_ready=%b done=%b required 1 0", load_ready, done);
    end
    load_word(w, 1'b0);
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (s !== 5'(k) || ser_out !== exp_bit(w, 1'b0, k)) begin
        n_fail++;
        $display("FAIL areset_rescan k=%0d: s=%0d ser_out=%b required s=%0d ser_out=%b",
                 k, s, ser_out, k, exp_bit(w, 1'b0, k));
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_rescan_done: done=%b required 1", done);
    end
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    msb_first  = 1'b0;
    abort      = 1'b0;
    ser_ready  = 1'b1;
    test_reset();
    test_lsb_scan();
    test_msb_scan();
    test_random();
    test_backpressure();
    test_busy_loads();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
